fetch_queue: RTL and testbench

Instruction-fetch stage directly downstream of the program counter register. Takes the current PC, issues one instruction-memory request at a time, buffers returned instructions with their PCs in a small FIFO for decode, and computes the next PC value fed back into the PC register's input. Owns sequential PC advance (PC+4), flush/redirect, and discarding of in-flight fetches after a redirect.

---
 rtl/fetch_queue_if.sv | 37 +++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request side and decode side.
// master = fetch_queue, slave = memory/decode environment.
interface fetch_queue_if #(
  parameter int bit_size  = 18,
  parameter int inst_size = 32
);
  logic                 imem_req;
  logic [bit_size-1:0]  imem_addr;
  logic                 imem_ack;
  logic [inst_size-1:0] imem_rdata;
  logic                 inst_valid;
  logic [inst_size-1:0] inst;
  logic [bit_size-1:0]  inst_pc;
  logic                 inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: one outstanding imem request, {pc,inst} FIFO, next-PC.
// Optional FETCH_BYPASS_EN: empty-queue fetch data goes straight to decode.
module fetch_queue #(
  parameter int bit_size  = 18,
  parameter int inst_size = 32,
  parameter int depth     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bit_size-1:0] pc_in,
  output logic [bit_size-1:0] pc_next,
  input  logic                flush,
  input  logic [bit_size-1:0] flush_target,
  fetch_queue_if.master       bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [bit_size-1:0] drop_q, drop_d;

  logic [bit_size-1:0]  pc_mem_q   [depth];
  logic [inst_size-1:0] inst_mem_q [depth];

  logic push;
  logic wr;
  logic pop;
`ifdef FETCH_BYPASS_EN
  logic byp;
`endif

  always_comb begin
    push = (state_q == FETCH) && bus.imem_ack && !flush;
    pop  = (count_q != '0) && bus.inst_ready && !flush;
    bus.imem_req  = (state_q != IDLE);
    bus.imem_addr = (state_q == DROP) ? drop_q : pc_in;
`ifdef FETCH_BYPASS_EN
    // A bypassed and accepted instruction never occupies a slot
    byp = push && (count_q == '0);
    wr  = push && !(byp && bus.inst_ready);
    bus.inst_valid = (count_q != '0) || byp;
    bus.inst    = byp ? bus.imem_rdata : inst_mem_q[rd_q];
    bus.inst_pc = byp ? pc_in : pc_mem_q[rd_q];
`else
    wr = push;
    bus.inst_valid = (count_q != '0);
    bus.inst    = inst_mem_q[rd_q];
    bus.inst_pc = pc_mem_q[rd_q];
`endif
  end

  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    drop_d  = drop_q;
    state_d = state_q;
    pc_next = pc_in;
    if (flush) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      pc_next = flush_target;
    end else begin
      count_d = count_q + CW'(wr) - CW'(pop);
      if (wr)   wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push) pc_next = pc_in + bit_size'(4);
    end
    unique case (state_q)
      IDLE: begin
        if (flush || count_d < CW'(depth))
          state_d = FETCH;
      end
      FETCH: begin
        // Unacked request at flush must still complete at its address
        if (flush) begin
          if (!bus.imem_ack) begin
            state_d = DROP;
            drop_d  = pc_in;
          end
        end else if (push && count_d == CW'(depth)) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (wr) begin
      pc_mem_q[wr_q]   <= pc_in;
      inst_mem_q[wr_q] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Random bench for fetch_queue: PC loop-back, random memory/decode/flush,
// scoreboard of expected {pc,inst} popped by an independent monitor.
module tb_fetch_queue;
  localparam int BS    = 18;
  localparam int IS    = 32;
  localparam int DEPTH = 4;
  localparam int NCYC  = 3000;

  typedef struct packed {
    logic [BS-1:0] pc;
    logic [IS-1:0] ins;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BS-1:0] pc_in = '0;
  logic [BS-1:0] pc_next;
  logic          flush = 1'b0;
  logic [BS-1:0] flush_target = '0;

  fetch_queue_if #(.bit_size(BS), .inst_size(IS)) bus ();

  fetch_queue #(
    .bit_size (BS),
    .inst_size(IS),
    .depth    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_next     (pc_next),
    .flush       (flush),
    .flush_target(flush_target),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   npop  = 0;
  int   nwrap = 0;
  int   ndrop = 0;
  int   pushed_now = 0;
  logic started = 1'b0;
  ent_t sb[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: decode side, compared against the scoreboard
  always @(negedge clk) begin
    if (started && !rst && !flush) begin
      int   n;
      ent_t e;
`ifdef FETCH_BYPASS_EN
      n = sb.size();
`else
      n = sb.size() - pushed_now;
`endif
      chk("inst_valid", bus.inst_valid, (n > 0));
      if (bus.inst_valid && bus.inst_ready) begin
        if (sb.size() == 0) begin
          chk("pop_empty_sb", 1, 0);
        end else begin
          e = sb.pop_front();
          npop++;
          chk("inst_pc", bus.inst_pc, e.pc);
          chk("inst", bus.inst, e.ins);
        end
      end
    end
  end

  // Driver: PC register, memory, decode readiness, flushes, model
  initial begin
    logic [BS-1:0] pc_model;
    logic [BS-1:0] drop_addr;
    logic [BS-1:0] prev_addr;
    logic [BS-1:0] exp_pc;
    logic [BS-1:0] addr;
    logic          drop;
    logic          was_drop;
    logic          prev_wait;
    logic          req;
    logic          ack;
    logic          acc;
    int            ack_pct;
    int            rdy_pct;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    pc_model  = '0;
    drop_addr = '0;
    prev_addr = '0;
    drop      = 1'b0;
    prev_wait = 1'b0;
    ack_pct   = 100;
    rdy_pct   = 100;
    pc_in     = 18'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_pc_next", pc_next, 18'h40);
    pc_in = '0;
    rst = 1'b0;
    started = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      if (c % 150 == 0 && c != 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 100;
          1: ack_pct = 25;
          default: ack_pct = 60;
        endcase
        case ($urandom_range(0, 2))
          0: rdy_pct = 100;
          1: rdy_pct = 0;
          default: rdy_pct = 50;
        endcase
      end
      @(posedge clk);
      #1;
      pc_in = pc_model;
      pushed_now = 0;
      #1;
      req  = bus.imem_req;
      addr = bus.imem_addr;
      chk("req_level", req, (sb.size() < DEPTH));
      if (prev_wait) begin
        chk("req_hold", req, 1);
        chk("addr_hold", addr, prev_addr);
      end
      if (drop) chk("drop_addr", addr, drop_addr);
      else if (req) chk("fetch_addr", addr, pc_model);
      flush = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0: flush_target = 18'h3FFFC;
        1: flush_target = 18'h00100;
        default: flush_target = {BS'($urandom) >> 2, 2'b00};
      endcase
      ack = req && ($urandom_range(0, 99) < ack_pct);
      bus.imem_ack   = ack;
      bus.imem_rdata = $urandom;
      bus.inst_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      was_drop = drop;
      acc = ack && !flush && !was_drop;
      if (flush) exp_pc = flush_target;
      else if (acc) exp_pc = pc_model + BS'(4);
      else exp_pc = pc_model;
      chk("pc_next", pc_next, exp_pc);
      if (acc && pc_model == 18'h3FFFC) nwrap++;
      if (flush) begin
        sb.delete();
        if (req && !ack) begin
          if (!was_drop) drop_addr = pc_model;
          drop = 1'b1;
          ndrop++;
        end else begin
          drop = 1'b0;
        end
      end else if (was_drop && ack) begin
        drop = 1'b0;
      end
      if (acc) begin
        sb.push_back('{pc: pc_model, ins: bus.imem_rdata});
        pushed_now = 1;
      end
      pc_model  = exp_pc;
      prev_wait = req && !ack;
      prev_addr = addr;
    end
    @(posedge clk);
    #1;
    chk("pops_seen", (npop > 20), 1);
    chk("wrap_seen", (nwrap > 0), 1);
    chk("drop_seen", (ndrop > 0), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
